dram_fifo_ctrl: RTL



---
 rtl/dram_fifo_pkg.sv | 23 ++
 rtl/RAM256X1D.sv | 26 ++
 rtl/dram_fifo_mem.sv | 29 ++
 rtl/dram_fifo_ctrl.sv | 103 ++++++++++
 4 files changed

// File: rtl/dram_fifo_pkg.sv
// Shared sizes, types and flag helpers for the LUT-RAM backed FIFO.
package dram_fifo_pkg;

    localparam int DEPTH = 256;
    localparam int PTR_W = 8;
    localparam int CNT_W = 9;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    function automatic logic is_full(input cnt_t cnt);
        return cnt == cnt_t'(DEPTH);
    endfunction

    function automatic logic is_afull(input cnt_t cnt, input cnt_t thr);
        return cnt >= thr;
    endfunction

    function automatic logic is_aempty(input cnt_t cnt, input cnt_t thr);
        return cnt <= thr;
    endfunction

endpackage

// File: rtl/RAM256X1D.sv
// Behavioural model of the 256x1 dual-port distributed RAM primitive.
module RAM256X1D #(
    parameter logic [255:0] INIT = 256'h0
) (
    output logic       DPO,
    output logic       SPO,
    input  logic [7:0] A,
    input  logic       D,
    input  logic [7:0] DPRA,
    input  logic       WCLK,
    input  logic       WE
);

    // Power-up contents only; nothing in the fabric reinitialises LUT-RAM.
    logic [255:0] mem = INIT;

    always_ff @(posedge WCLK) begin
        if (WE) begin
            mem[A] <= D;
        end
    end

    assign SPO = mem[A];
    assign DPO = mem[DPRA];

endmodule

// File: rtl/dram_fifo_mem.sv
// Storage array: one 256x1 dual-port LUT-RAM per data bit.
module dram_fifo_mem
    import dram_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             we,
    input  ptr_t             wr_addr,
    input  ptr_t             rd_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        RAM256X1D #(
            .INIT(256'h0)
        ) u_ram (
            .DPO  (rd_data[i]),
            .SPO  (),
            .A    (wr_addr),
            .D    (wr_data[i]),
            .DPRA (rd_addr),
            .WCLK (clk),
            .WE   (we)
        );
    end

endmodule

// File: rtl/dram_fifo_ctrl.sv
// 256-deep synchronous FIFO controller over distributed RAM with registered read data.
module dram_fifo_ctrl
    import dram_fifo_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned AFULL_THR  = 240,
    parameter int unsigned AEMPTY_THR = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLR,
    input  logic             WR_EN,
    input  logic [WIDTH-1:0] WR_DATA,
    input  logic             RD_EN,
    output logic [WIDTH-1:0] RD_DATA,
    output logic             RD_VAL,
    output logic             FULL,
    output logic             EMPTY,
    output logic             ALMOST_FULL,
    output logic             ALMOST_EMPTY,
    output cnt_t             COUNT,
    output logic             OVF,
    output logic             UDF
);

    localparam cnt_t AF_THR = cnt_t'(AFULL_THR);
    localparam cnt_t AE_THR = cnt_t'(AEMPTY_THR);

    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    logic [WIDTH-1:0] dpo;
    logic             push_ok;
    logic             pop_ok;
    logic             we;
    cnt_t             count_nxt;

    assign push_ok   = WR_EN & ~FULL;
    assign pop_ok    = RD_EN & ~EMPTY;
    // Reset is folded into WE so an asynchronous reset mid-burst cannot corrupt RAM.
    assign we        = push_ok & ~CLR & RST_N;
    assign count_nxt = COUNT + cnt_t'(push_ok) - cnt_t'(pop_ok);

    dram_fifo_mem #(
        .WIDTH(WIDTH)
    ) u_mem (
        .clk     (CLK),
        .we      (we),
        .wr_addr (wr_ptr),
        .rd_addr (rd_ptr),
        .wr_data (WR_DATA),
        .rd_data (dpo)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            COUNT        <= '0;
            FULL         <= 1'b0;
            EMPTY        <= 1'b1;
            ALMOST_FULL  <= is_afull(cnt_t'(0), AF_THR);
            ALMOST_EMPTY <= 1'b1;
            RD_DATA      <= '0;
            RD_VAL       <= 1'b0;
            OVF          <= 1'b0;
            UDF          <= 1'b0;
        end else if (CLR) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            COUNT        <= '0;
            FULL         <= 1'b0;
            EMPTY        <= 1'b1;
            ALMOST_FULL  <= is_afull(cnt_t'(0), AF_THR);
            ALMOST_EMPTY <= 1'b1;
            RD_DATA      <= '0;
            RD_VAL       <= 1'b0;
            OVF          <= 1'b0;
            UDF          <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + ptr_t'(push_ok);
            rd_ptr <= rd_ptr + ptr_t'(pop_ok);
            if (pop_ok) begin
                RD_DATA <= dpo;
            end
            RD_VAL <= pop_ok;

            // Flags follow the next-state count so they move on the same edge as COUNT.
            COUNT        <= count_nxt;
            FULL         <= is_full(count_nxt);
            EMPTY        <= (count_nxt == '0);
            ALMOST_FULL  <= is_afull(count_nxt, AF_THR);
            ALMOST_EMPTY <= is_aempty(count_nxt, AE_THR);

            if (WR_EN && FULL) begin
                OVF <= 1'b1;
            end
            if (RD_EN && EMPTY) begin
                UDF <= 1'b1;
            end
        end
    end

endmodule
